// File: rtl/i2c_target_byte.sv
// i2c_target_byte: I2C target that oversamples SCL/SDA on i_Clk, decodes START/STOP,
//   ACKs TARGET_ADDR and moves whole bytes to/from a byte-level user interface.
// Latency: bus edges are seen SYNC_STAGES+1 cycles late; SDA changes the cycle after an
//   SCL fall detect; o_RX_DV pulses one cycle after o_RX_Byte updates.
// Backpressure: every written byte is ACKed. A read with an empty holding register
//   returns 8'hFF, unless I2C_TARGET_CLK_STRETCH_EN is defined, which holds SCL low until i_TX_DV.
// Ports: i_Clk/i_Rst_L clock and async active-low reset; i2c_scl/i2c_sda open-drain bus;
//   o_RX_DV/o_RX_Byte write data out; i_TX_DV/i_TX_Byte/o_TX_Taken read data in;
//   o_Start/o_Stop bus-condition pulses; o_Busy addressed flag; o_RW last matched R/W bit.
// SYNC_STAGES must be 2 or 3.
module i2c_target_byte #(
  parameter logic [6:0] TARGET_ADDR = 7'b0101010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Taken,
  output logic       o_Start,
  output logic       o_Stop,
  output logic       o_Busy,
  output logic       o_RW
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_DATA, ST_RX_ACK, ST_TX_DATA, ST_TX_ACK, ST_IGNORE
  } state_t;

  // Input synchronizers and edge detect
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_cond = scl_s & ~sda_s & sda_prev_q;
  assign stop_cond  = scl_s & sda_s & ~sda_prev_q;

  // Control state
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  // phase_q: ACK states - ACK drive has begun; TX_DATA - all 8 bits clocked out;
  // TX_ACK - master ACKed, reload on the coming SCL fall.
  logic        phase_q, phase_d;
  logic        sda_low_q, sda_low_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_pend_q, rx_pend_d;
  logic        rx_dv_q, rx_dv_d;
  logic        start_q, start_d;
  logic        stop_q, stop_d;
  logic        taken_q, taken_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  rx_bits, load_byte;
  logic        load, tx_enter, stretch_wait;

`ifdef I2C_TARGET_CLK_STRETCH_EN
  logic        stretch_q, stretch_d;
  logic        scl_low_q, scl_low_d;
  logic [1:0]  rel_cnt_q, rel_cnt_d;
  assign stretch_wait = stretch_q;
`else
  assign stretch_wait = 1'b0;
`endif

  assign rx_bits   = {shift_q[6:0], sda_s};
  assign load_byte = hold_vld_q ? hold_q : 8'hFF;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    sda_low_d  = sda_low_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_byte_d  = rx_byte_q;
    rx_pend_d  = 1'b0;
    rx_dv_d    = rx_pend_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    taken_d    = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    load       = 1'b0;
    tx_enter   = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    stretch_d  = stretch_q;
    scl_low_d  = scl_low_q;
    rel_cnt_d  = rel_cnt_q;
`endif

    if (start_cond) begin
      // START or repeated START aborts whatever byte was in flight
      start_d   = 1'b1;
      state_d   = ST_ADDR;
      cnt_d     = 3'd0;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      stretch_d = 1'b0;
      scl_low_d = 1'b0;
      rel_cnt_d = 2'd0;
`endif
    end else if (stop_cond) begin
      stop_d    = 1'b1;
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      phase_d   = 1'b0;
      sda_low_d = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
      stretch_d = 1'b0;
      scl_low_d = 1'b0;
      rel_cnt_d = 2'd0;
`endif
    end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
      // SDA already carries the first bit; release SCL two cycles later
      if (rel_cnt_q != 2'd0) begin
        rel_cnt_d = rel_cnt_q - 2'd1;
        if (rel_cnt_q == 2'd1) scl_low_d = 1'b0;
      end
`endif
      case (state_q)
        ST_IDLE, ST_IGNORE: sda_low_d = 1'b0;

        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = rx_bits;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (rx_bits[7:1] == TARGET_ADDR) begin
                rw_d    = rx_bits[0];
                busy_d  = 1'b1;
                phase_d = 1'b0;
                state_d = ST_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = ST_IGNORE;
              end
            end
          end
        end

        // First SCL fall starts the ACK drive, the second one ends it
        ST_ADDR_ACK, ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_low_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = 3'd0;
              if (state_q == ST_RX_ACK || !rw_q) begin
                state_d   = ST_RX_DATA;
                sda_low_d = 1'b0;
              end else begin
                tx_enter = 1'b1;
              end
            end
          end
        end

        ST_RX_DATA: begin
          if (scl_rise) begin
            shift_d = rx_bits;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_byte_d = rx_bits;
              rx_pend_d = 1'b1;
              phase_d   = 1'b0;
              state_d   = ST_RX_ACK;
            end
          end
        end

        ST_TX_DATA: begin
          if (stretch_wait) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
            if (hold_vld_q) begin
              load      = 1'b1;
              shift_d   = hold_q;
              sda_low_d = ~hold_q[7];
              stretch_d = 1'b0;
              rel_cnt_d = 2'd2;
            end
`endif
          end else if (scl_rise) begin
            // Master has sampled bit 7 of the shifter; move the next bit up
            shift_d = {shift_q[6:0], 1'b1};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) phase_d = 1'b1;
          end else if (scl_fall) begin
            if (phase_q) begin
              phase_d   = 1'b0;
              sda_low_d = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              sda_low_d = ~shift_q[7];
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_IGNORE;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d  = 1'b0;
            tx_enter = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (tx_enter) begin
        state_d = ST_TX_DATA;
        cnt_d   = 3'd0;
        phase_d = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
        if (!hold_vld_q) begin
          stretch_d = 1'b1;
          scl_low_d = 1'b1;
          sda_low_d = 1'b0;
        end else begin
          load      = 1'b1;
          shift_d   = load_byte;
          sda_low_d = ~load_byte[7];
        end
`else
        load      = 1'b1;
        shift_d   = load_byte;
        sda_low_d = ~load_byte[7];
`endif
      end
    end

    // A same-cycle i_TX_DV wins over the clear, so the new byte stays valid
    if (load && hold_vld_q) begin
      hold_vld_d = 1'b0;
      taken_d    = 1'b1;
    end
    if (i_TX_DV) begin
      hold_d     = i_TX_Byte;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      cnt_q      <= 3'd0;
      phase_q    <= 1'b0;
      sda_low_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_pend_q  <= 1'b0;
      rx_dv_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      taken_q    <= 1'b0;
      hold_q     <= 8'hFF;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      sda_low_q  <= sda_low_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_byte_q  <= rx_byte_d;
      rx_pend_q  <= rx_pend_d;
      rx_dv_q    <= rx_dv_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      taken_q    <= taken_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

`ifdef I2C_TARGET_CLK_STRETCH_EN
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stretch_q <= 1'b0;
      scl_low_q <= 1'b0;
      rel_cnt_q <= 2'd0;
    end else begin
      stretch_q <= stretch_d;
      scl_low_q <= scl_low_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end
  assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
`else
  assign i2c_scl = 1'bz;
`endif

  // Open-drain: only ever pull low
  assign i2c_sda    = sda_low_q ? 1'b0 : 1'bz;

  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_byte_q;
  assign o_TX_Taken = taken_q;
  assign o_Start    = start_q;
  assign o_Stop     = stop_q;
  assign o_Busy     = busy_q;
  assign o_RW       = rw_q;

endmodule
